// File: rtl/cache_miss_ctrl.sv
// Miss controller for a set-associative cache: round-robin arbitration over N_REQ readers,
// one lookup at a time, line fetch from backing memory on miss, then fill and respond.
module cache_miss_ctrl #(
  parameter int unsigned N_REQ      = 2,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned LINE_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [N_REQ-1:0]            req_ready,
  output logic [N_REQ-1:0]            resp_valid,
  output logic [LINE_WIDTH-1:0]       resp_data,
  output logic [ADDR_WIDTH-1:0]       c_addr,
  output logic [LINE_WIDTH-1:0]       c_val,
  output logic                        c_read,
  output logic                        c_write,
  input  logic                        c_hit,
  input  logic [LINE_WIDTH-1:0]       c_out_val,
  output logic                        mem_req_valid,
  input  logic                        mem_req_ready,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  input  logic                        mem_resp_valid,
  input  logic [LINE_WIDTH-1:0]       mem_resp_data,
  output logic [CNT_WIDTH-1:0]        hit_count,
  output logic [CNT_WIDTH-1:0]        miss_count
);

  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    StIdle, StLookup, StCheck, StMreq, StMwait, StFill, StResp
  } state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] line_q, line_d;
  logic [CNT_WIDTH-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_WIDTH-1:0]  miss_cnt_q, miss_cnt_d;

  logic [N_REQ-1:0]      grant;
  logic [IdxW-1:0]       grant_idx;
  logic [ADDR_WIDTH-1:0] grant_addr;
  logic                  found;
  int unsigned           cand;

  // Priority scan starts just after the last winner so a held request wins within N_REQ turns.
  always_comb begin
    grant      = '0;
    grant_idx  = rr_ptr_q;
    grant_addr = '0;
    found      = 1'b0;
    cand       = 0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      cand = (32'(rr_ptr_q) + off) % N_REQ;
      if (!found && req_valid[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand[IdxW-1:0];
        grant_addr  = req_addr[cand*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      rr_ptr_q   <= IdxW'(N_REQ - 1);
      idx_q      <= '0;
      addr_q     <= '0;
      line_q     <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      line_q     <= line_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    line_d     = line_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d  = StLookup;
          addr_d   = grant_addr;
          idx_d    = grant_idx;
          rr_ptr_d = grant_idx;
        end
      end
      StLookup: state_d = StCheck;
      StCheck: begin
        if (c_hit) begin
          line_d  = c_out_val;
          state_d = StResp;
          if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 1'b1;
        end else begin
          state_d = StMreq;
          if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 1'b1;
        end
      end
      StMreq: begin
        if (mem_req_ready) state_d = StMwait;
      end
      StMwait: begin
        if (mem_resp_valid) begin
          line_d  = mem_resp_data;
          state_d = StFill;
        end
      end
      StFill:  state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready     = (state_q == StIdle && !reset) ? grant : '0;
    c_read        = (state_q == StLookup);
    c_write       = (state_q == StFill);
    c_addr        = (c_read || c_write) ? addr_q : '0;
    c_val         = c_write ? line_q : '0;
    mem_req_valid = (state_q == StMreq);
    mem_addr      = mem_req_valid ? addr_q : '0;
    resp_valid    = '0;
    resp_data     = '0;
    if (state_q == StResp) begin
      resp_valid[idx_q] = 1'b1;
      resp_data         = line_q;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Directed bench for cache_miss_ctrl; a second instance with 2-bit counters checks saturation.
module tb_cache_miss_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [15:0] req_addr = '0;
  logic        c_hit = 1'b0;
  logic [31:0] c_out_val = '0;
  logic        mem_req_ready = 1'b0;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = '0;

  logic [1:0]  req_ready, resp_valid;
  logic [31:0] resp_data, c_val;
  logic [7:0]  c_addr, mem_addr;
  logic        c_read, c_write, mem_req_valid;
  logic [15:0] hit_count, miss_count;

  logic [1:0]  s_req_ready, s_resp_valid;
  logic [31:0] s_resp_data, s_c_val;
  logic [7:0]  s_c_addr, s_mem_addr;
  logic        s_c_read, s_c_write, s_mem_req_valid;
  logic [1:0]  s_hit_count, s_miss_count;

  int checks = 0;
  int errors = 0;
  int cw_n = 0;
  int rv_n = 0;
  int mr_n = 0;

  cache_miss_ctrl #(.N_REQ(2), .ADDR_WIDTH(8), .LINE_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
    .c_addr(c_addr), .c_val(c_val), .c_read(c_read), .c_write(c_write),
    .c_hit(c_hit), .c_out_val(c_out_val), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_addr(mem_addr), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data), .hit_count(hit_count), .miss_count(miss_count)
  );

  cache_miss_ctrl #(.N_REQ(2), .ADDR_WIDTH(8), .LINE_WIDTH(32), .CNT_WIDTH(2)) dut_sat (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(s_req_ready), .resp_valid(s_resp_valid), .resp_data(s_resp_data),
    .c_addr(s_c_addr), .c_val(s_c_val), .c_read(s_c_read), .c_write(s_c_write),
    .c_hit(c_hit), .c_out_val(c_out_val), .mem_req_valid(s_mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_addr(s_mem_addr), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data), .hit_count(s_hit_count), .miss_count(s_miss_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (c_write) cw_n <= cw_n + 1;
    if (resp_valid != 2'b00) rv_n <= rv_n + 1;
    if (mem_req_valid) mr_n <= mr_n + 1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    c_hit = 1'b0;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    int cw0, rv0;
    do_reset();
    checks++;
    if ({req_ready, resp_valid, resp_data, c_addr, c_val, c_read, c_write, mem_req_valid,
         mem_addr, hit_count, miss_count} !== '0) begin
      errors++; $display("FAIL reset_outputs got nonzero outputs");
    end
    req_valid = 2'b01; req_addr = 16'h0020;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++; $display("FAIL rst_first_grant got %b exp 01", req_ready);
    end
    tick();                                   // LOOKUP
    req_valid = '0;
    tick();                                   // CHECK, miss
    tick();                                   // MREQ
    mem_req_ready = 1'b1;
    tick();                                   // MWAIT
    mem_req_ready = 1'b0;
    checks++;
    if (miss_count !== 16'd1) begin
      errors++; $display("FAIL rst_pre_miss got %0d exp 1", miss_count);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (miss_count !== 16'd0 || mem_req_valid !== 1'b0) begin
      errors++; $display("FAIL rst_async got miss=%0d mrv=%b exp 0 0", miss_count, mem_req_valid);
    end
    tick();
    reset = 1'b0;
    cw0 = cw_n; rv0 = rv_n;
    mem_resp_valid = 1'b1; mem_resp_data = 32'hAAAA5555;
    repeat (4) tick();
    mem_resp_valid = 1'b0;
    checks++;
    if (cw_n != cw0 || rv_n != rv0) begin
      errors++; $display("FAIL rst_drop got cw=%0d rv=%0d exp 0 0", cw_n - cw0, rv_n - rv0);
    end
    checks++;
    if (hit_count !== 16'd0 || miss_count !== 16'd0) begin
      errors++; $display("FAIL rst_counters got %0d %0d exp 0 0", hit_count, miss_count);
    end
    req_valid = 2'b10; req_addr = 16'h4400;
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      errors++; $display("FAIL rst_idle got %b exp 10", req_ready);
    end
    req_valid = '0;
    #1;
  endtask

  task automatic test_miss();
    int cw0;
    cw0 = cw_n;
    req_valid = 2'b01; req_addr = 16'h0014; c_hit = 1'b0;
    tick();                                   // LOOKUP
    req_valid = '0;
    checks++;
    if (c_read !== 1'b1 || c_addr !== 8'h14 || c_write !== 1'b0) begin
      errors++; $display("FAIL miss_lookup got rd=%b addr=%h wr=%b exp 1 14 0", c_read, c_addr, c_write);
    end
    tick();                                   // CHECK
    tick();                                   // MREQ
    checks++;
    if (mem_req_valid !== 1'b1 || mem_addr !== 8'h14) begin
      errors++; $display("FAIL miss_mreq got v=%b a=%h exp 1 14", mem_req_valid, mem_addr);
    end
    mem_req_ready = 1'b1;
    tick();                                   // MWAIT
    mem_req_ready = 1'b0;
    tick();
    tick();
    mem_resp_valid = 1'b1; mem_resp_data = 32'hDEADBEEF;
    tick();                                   // FILL
    mem_resp_valid = 1'b0;
    checks++;
    if (c_write !== 1'b1 || c_read !== 1'b0 || c_addr !== 8'h14 || c_val !== 32'hDEADBEEF) begin
      errors++; $display("FAIL miss_fill got wr=%b rd=%b a=%h v=%h exp 1 0 14 deadbeef",
                         c_write, c_read, c_addr, c_val);
    end
    tick();                                   // RESP
    checks++;
    if (resp_valid !== 2'b01 || resp_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL miss_resp got %b %h exp 01 deadbeef", resp_valid, resp_data);
    end
    tick();                                   // IDLE
    checks++;
    if (resp_valid !== 2'b00 || resp_data !== 32'h0 || miss_count !== 16'd1 || cw_n != cw0 + 1) begin
      errors++; $display("FAIL miss_after got rv=%b d=%h miss=%0d cw=%0d exp 00 0 1 1",
                         resp_valid, resp_data, miss_count, cw_n - cw0);
    end
  endtask

  task automatic test_hit();
    int mr0;
    mr0 = mr_n;
    req_valid = 2'b01; req_addr = 16'h0014;
    tick();                                   // cycle 1 LOOKUP
    req_valid = '0;
    tick();                                   // cycle 2 CHECK
    c_hit = 1'b1; c_out_val = 32'hDEADBEEF;
    checks++;
    if (resp_valid !== 2'b00) begin
      errors++; $display("FAIL hit_early got %b exp 00", resp_valid);
    end
    tick();                                   // cycle 3 RESP
    c_hit = 1'b0; c_out_val = '0;
    checks++;
    if (resp_valid !== 2'b01 || resp_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL hit_resp got %b %h exp 01 deadbeef", resp_valid, resp_data);
    end
    tick();
    checks++;
    if (hit_count !== 16'd1 || mr_n != mr0) begin
      errors++; $display("FAIL hit_after got hit=%0d mreq=%0d exp 1 0", hit_count, mr_n - mr0);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g [4];
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
    do_reset();
    req_valid = 2'b11; req_addr = 16'h2211; c_hit = 1'b1; c_out_val = 32'h0000CAFE;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (req_ready !== exp_g[i]) begin
        errors++; $display("FAIL rr_grant%0d got %b exp %b", i, req_ready, exp_g[i]);
      end
      tick();
      checks++;
      if (c_addr !== (exp_g[i] == 2'b01 ? 8'h11 : 8'h22)) begin
        errors++; $display("FAIL rr_addr%0d got %h", i, c_addr);
      end
      tick();
      tick();
      checks++;
      if (resp_valid !== exp_g[i]) begin
        errors++; $display("FAIL rr_resp%0d got %b exp %b", i, resp_valid, exp_g[i]);
      end
      tick();
    end
    req_valid = '0; c_hit = 1'b0;
    #1;
  endtask

  task automatic test_mem_stall();
    req_valid = 2'b01; req_addr = 16'h003C;
    tick();
    req_valid = 2'b10; req_addr = 16'h773C;
    tick();
    tick();                                   // MREQ
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (mem_req_valid !== 1'b1 || mem_addr !== 8'h3C || req_ready !== 2'b00) begin
        errors++; $display("FAIL stall%0d got v=%b a=%h rdy=%b exp 1 3c 00",
                           i, mem_req_valid, mem_addr, req_ready);
      end
      tick();
    end
    mem_req_ready = 1'b1;
    checks++;
    if (mem_req_valid !== 1'b1) begin
      errors++; $display("FAIL stall_hs got %b exp 1", mem_req_valid);
    end
    tick();                                   // MWAIT
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = 32'h12345678;
    tick();                                   // FILL
    mem_resp_valid = 1'b0;
    tick();                                   // RESP
    checks++;
    if (resp_valid !== 2'b01 || resp_data !== 32'h12345678) begin
      errors++; $display("FAIL stall_resp got %b %h exp 01 12345678", resp_valid, resp_data);
    end
    tick();
    checks++;
    if (req_ready !== 2'b10) begin
      errors++; $display("FAIL stall_pending got %b exp 10", req_ready);
    end
    req_valid = '0;
    #1;
  endtask

  task automatic test_saturation();
    do_reset();
    req_valid = 2'b01; req_addr = 16'h0005; c_hit = 1'b1; c_out_val = 32'h1;
    for (int i = 0; i < 5; i++) begin
      repeat (4) tick();
    end
    req_valid = '0; c_hit = 1'b0;
    tick();
    checks++;
    if (s_hit_count !== 2'd3) begin
      errors++; $display("FAIL sat_hit got %0d exp 3", s_hit_count);
    end
    checks++;
    if (hit_count !== 16'd5 || s_miss_count !== 2'd0) begin
      errors++; $display("FAIL sat_wide got %0d %0d exp 5 0", hit_count, s_miss_count);
    end
  endtask

  initial begin
    test_reset();
    test_miss();
    test_hit();
    test_round_robin();
    test_mem_stall();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
